// File: rtl/k005297_timer25k_ctrl.sv
// k005297_timer25k_ctrl: round-robin sequencer that clears, runs and snapshots the shared 2556-frame serial timer
// Ports: i_MCLK clock, i_RST sync active-high reset, i_CLK2M_PCEN_n tick enable (low = tick),
//   i_ROT20_n 20-slot ring (one bit low), i_REQ/i_STOP per-requester request level and stop pulse,
//   i_TIMER25K_TIMEOVER_n time-over from timer; o_TIMER25K_CNT count enable, o_TIMER25K_OUTLATCH_LD_n latch load,
//   o_GNT one-hot owner, o_BUSY not idle, o_TIMEOUT/o_STOPPED one-tick completion pulses to the owner.
module k005297_timer25k_ctrl (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_CLK2M_PCEN_n,
  input  logic [19:0] i_ROT20_n,
  input  logic [1:0]  i_REQ,
  input  logic [1:0]  i_STOP,
  input  logic        i_TIMER25K_TIMEOVER_n,
  output logic        o_TIMER25K_CNT,
  output logic        o_TIMER25K_OUTLATCH_LD_n,
  output logic [1:0]  o_GNT,
  output logic        o_BUSY,
  output logic [1:0]  o_TIMEOUT,
  output logic [1:0]  o_STOPPED
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_SNAP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  logic [2:0] r_state, w_state;
  logic [4:0] w_slot;
  logic       r_ptr, r_cnt, r_ld_n, r_busy, r_by_stop;
  logic [1:0] r_gnt, r_tmo, r_stp, w_pick;
  logic       w_tick, w_s12, w_s19, w_tov, w_stop;
  always_comb begin
    w_slot = 5'd0;
    for (int k = 0; k < 20; k++)
      if (!i_ROT20_n[k]) w_slot = 5'(k);
  end
  // the latch load is issued one slot early so the timer sees it low on the slot-13 tick
  always_comb begin
    w_tick = ~i_CLK2M_PCEN_n;
    w_s12 = w_slot == 5'd12;
    w_s19 = w_slot == 5'd19;
    w_tov = ~i_TIMER25K_TIMEOVER_n;
    w_stop = |(i_STOP & r_gnt);
    w_pick = (r_ptr ? i_REQ[1] : ~i_REQ[0]) ? 2'b10 : 2'b01;
    w_state = r_state;
    case (r_state)
      S_IDLE:  w_state = |i_REQ ? S_ALIGN : S_IDLE;
      S_ALIGN: w_state = w_s19 ? S_CLEAR : S_ALIGN;
      S_CLEAR: w_state = w_s19 ? S_RUN : S_CLEAR;
      S_RUN:   w_state = (w_tov | w_stop) ? S_SNAP : S_RUN;
      S_SNAP:  w_state = r_ld_n ? S_SNAP : S_DONE;
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      r_state <= S_IDLE;
      r_busy <= 1'b0;
      r_gnt <= 2'b00;
      r_cnt <= 1'b0;
      r_ld_n <= 1'b1;
      r_by_stop <= 1'b0;
      r_tmo <= 2'b00;
      r_stp <= 2'b00;
      r_ptr <= 1'b0;
    end else if (w_tick) begin
      r_state <= w_state;
      r_busy <= w_state != S_IDLE;
      r_gnt <= (r_state == S_IDLE && |i_REQ) ? w_pick : (w_state == S_DONE ? 2'b00 : r_gnt);
      r_cnt <= (r_state == S_CLEAR && w_s19) ? 1'b1 : (w_state == S_DONE ? 1'b0 : r_cnt);
      r_ld_n <= ~(w_s12 && w_state == S_SNAP);
      r_by_stop <= r_state == S_RUN ? ~w_tov : r_by_stop;
      r_tmo <= (r_state == S_RUN && w_tov) ? r_gnt : 2'b00;
      r_stp <= (r_state == S_SNAP && !r_ld_n && r_by_stop) ? r_gnt : 2'b00;
      r_ptr <= w_state == S_DONE ? r_gnt[0] : r_ptr;
    end
  end
  assign o_TIMER25K_CNT = r_cnt;
  assign o_TIMER25K_OUTLATCH_LD_n = r_ld_n;
  assign o_GNT = r_gnt;
  assign o_BUSY = r_busy;
  assign o_TIMEOUT = r_tmo;
  assign o_STOPPED = r_stp;
endmodule

// File: tb/tb_k005297_timer25k_ctrl.sv
// tb_k005297_timer25k_ctrl: randomized scoreboard bench with a frame-level timer model
module tb_k005297_timer25k_ctrl;
  typedef struct {int kind; int lo; int hi;} exp_t;
  logic clk = 0;
  logic rst = 1, pcen_n = 0, tov_n = 1;
  logic [19:0] rot_n = ~20'd1;
  logic [1:0] req = 0, stp = 0;
  logic cnt, ld_n, busy;
  logic [1:0] gnt, tmo, stopped;
  exp_t sb[$];
  int tests = 0, fails = 0;
  int slot = 0, tcount = 0, term = 40, tick_n = 0, latched = -1, n_gnt = 0, gnt_tick = 0;
  int tov_tick = -100, own_stop_tick = -100, ld_tick = -100, ld_slot = -1;
  bit frame_lo = 1, frame_hi = 1, dense = 0, stop_on_tov = 0, in_tmo = 0, rst_q = 1;
  logic [1:0] pend_stop = 0, p_gnt = 0, p_tmo = 0, p_stp = 0;
  logic p_cnt = 0, p_ld = 1;
  always #5 clk = ~clk;
  k005297_timer25k_ctrl dut (
    .i_MCLK(clk), .i_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_ROT20_n(rot_n), .i_REQ(req), .i_STOP(stp),
    .i_TIMER25K_TIMEOVER_n(tov_n), .o_TIMER25K_CNT(cnt), .o_TIMER25K_OUTLATCH_LD_n(ld_n), .o_GNT(gnt),
    .o_BUSY(busy), .o_TIMEOUT(tmo), .o_STOPPED(stopped)
  );
  function automatic string kn(int k);
    return k == 0 ? "grant" : k == 1 ? "timeout" : k == 2 ? "stopped" : "latch";
  endfunction
  task automatic chk(string nm, int act, int lo, int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask
  task automatic bound(string nm, bit ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got no event, want event within cycle limit", nm);
    end
  endtask
  task automatic push(int k, int lo, int hi);
    exp_t e;
    e.kind = k; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask
  task automatic sb_check(int k, int v);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL sb_unexpected: got %s=%0d, want no event", kn(k), v);
    end else begin
      e = sb.pop_front();
      chk({"sb_kind_", kn(e.kind)}, k, e.kind, e.kind);
      chk({"sb_", kn(e.kind)}, v, e.lo, e.hi);
    end
  endtask
  task automatic monitor();
    if (gnt != 0 && p_gnt == 0) begin
      n_gnt++; gnt_tick = tick_n; in_tmo = 0;
      sb_check(0, int'(gnt));
      chk("busy_at_grant", int'(busy), 1, 1);
    end
    if (gnt == 0 && p_gnt != 0) chk("cnt_off_at_release", int'(cnt), 0, 0);
    if (cnt && !p_cnt) begin
      chk("run_start_slot", slot, 0, 0);
      chk("grant_to_run", tick_n - gnt_tick, 21, 40);
    end
    if (p_tmo != 0) chk("timeout_width", int'(tmo), 0, 0);
    if (p_stp != 0) chk("stopped_width", int'(stopped), 0, 0);
    if (tmo != 0 && p_tmo == 0) begin
      in_tmo = 1;
      sb_check(1, int'(tmo));
      chk("timeout_latency", tick_n - tov_tick, 0, 0);
    end
    if (!p_ld) begin
      chk("ld_width", int'(ld_n), 1, 1);
      chk("ld_slot", ld_slot, 13, 13);
      sb_check(3, latched);
      if (in_tmo) chk("ld_after_timeover", ld_tick - tov_tick, 20, 20);
      else chk("ld_after_stop", ld_tick - own_stop_tick, 1, 20);
    end
    if (stopped != 0 && p_stp == 0) begin
      sb_check(2, int'(stopped));
      chk("stopped_after_ld", tick_n - ld_tick, 0, 0);
    end
  endtask
  // environment: slot ring, tick enable, frame-level timer model and the output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!pcen_n) begin
        tick_n++;
        if (!p_ld) begin latched = tcount; ld_tick = tick_n; ld_slot = slot; end
        frame_lo = frame_lo && !p_cnt;
        frame_hi = frame_hi && p_cnt;
        if (slot == 19) begin
          tcount = frame_lo ? 0 : frame_hi ? (tcount + 1) % 4096 : tcount;
          frame_lo = 1; frame_hi = 1;
        end
        if (!tov_n) tov_tick = tick_n;
        if ((stp & p_gnt) != 0) own_stop_tick = tick_n;
        stp = 2'b00;
        slot = (slot + 1) % 20;
        if (!rst_q) monitor();
      end
      p_gnt = gnt; p_tmo = tmo; p_stp = stopped; p_cnt = cnt; p_ld = ld_n;
      pcen_n = dense ? 1'b0 : ($urandom_range(0, 3) == 0);
      rot_n = ~(20'd1 << slot);
      tov_n = !(slot == 13 && tcount == term - 1 && cnt);
      if (!tov_n && stop_on_tov) begin stp = gnt; stop_on_tov = 0; end
      else if (stp == 0 && pend_stop != 0) begin stp = pend_stop; pend_stop = 0; end
      rst_q = rst;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(string nm);
    chk({nm, "_cnt"}, int'(cnt), 0, 0);
    chk({nm, "_ld_n"}, int'(ld_n), 1, 1);
    chk({nm, "_gnt"}, int'(gnt), 0, 0);
    chk({nm, "_busy"}, int'(busy), 0, 0);
    chk({nm, "_timeout"}, int'(tmo), 0, 0);
    chk({nm, "_stopped"}, int'(stopped), 0, 0);
  endtask
  task automatic wait_idle(string nm, int lim);
    int n = 0;
    while (!(sb.size() == 0 && !busy) && n < lim) begin step(); n++; end
    bound(nm, n < lim);
    repeat (5) step();
  endtask
  initial begin
    int n;
    repeat (6) step();
    chk_reset("reset");
    rst = 0;
    repeat (40) step();
    chk("idle_busy", int'(busy), 0, 0);
    chk("idle_gnt", int'(gnt), 0, 0);
    term = 40;
    for (int i = 0; i < 3; i++) begin
      push(0, (i % 2) ? 2 : 1, (i % 2) ? 2 : 1);
      push(1, (i % 2) ? 2 : 1, (i % 2) ? 2 : 1);
      push(3, 40, 40);
    end
    req = 2'b11;
    n = 0;
    while (!(n_gnt >= 1 && tcount >= 10 && cnt) && n < 5000) begin step(); n++; end
    bound("wait_nonowner_stop", n < 5000);
    pend_stop = 2'b10;
    n = 0;
    while (n_gnt < 3 && n < 20000) begin step(); n++; end
    bound("wait_third_grant", n < 20000);
    req = 2'b00;
    wait_idle("arb_done", 10000);
    term = 200;
    push(0, 2, 2); push(3, 100, 101); push(2, 2, 2);
    req = 2'b10;
    n = 0;
    while (n_gnt < 4 && n < 2000) begin step(); n++; end
    bound("wait_stop_grant", n < 2000);
    req = 2'b00;
    n = 0;
    while (!(tcount >= 100 && cnt) && n < 10000) begin step(); n++; end
    bound("wait_frame100", n < 10000);
    pend_stop = 2'b10;
    wait_idle("stop_done", 2000);
    term = 40;
    push(0, 1, 1); push(1, 1, 1); push(3, 40, 40);
    stop_on_tov = 1;
    req = 2'b01;
    n = 0;
    while (n_gnt < 5 && n < 2000) begin step(); n++; end
    bound("wait_collision_grant", n < 2000);
    req = 2'b00;
    wait_idle("collision_done", 5000);
    chk("collision_applied", int'(stop_on_tov), 0, 0);
    dense = 1;
    term = 2556;
    push(0, 2, 2);
    req = 2'b10;
    n = 0;
    while (n_gnt < 6 && n < 2000) begin step(); n++; end
    bound("wait_long_grant", n < 2000);
    req = 2'b00;
    n = 0;
    while (!(tcount >= 500 && cnt) && n < 20000) begin step(); n++; end
    bound("wait_frame500", n < 20000);
    rst = 1;
    step();
    chk_reset("midrun_reset");
    chk("sb_before_reset", sb.size(), 0, 0);
    rst = 0;
    step();
    push(0, 1, 1); push(1, 1, 1); push(3, 2556, 2556);
    req = 2'b01;
    n = 0;
    while (n_gnt < 7 && n < 2000) begin step(); n++; end
    bound("wait_full_grant", n < 2000);
    req = 2'b00;
    wait_idle("full_done", 60000);
    chk("sb_drained", sb.size(), 0, 0);
    chk("grant_count", n_gnt, 7, 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
